// File: rtl/reg_file.sv
// Purpose: 32x32 register file with one write port, two read ports, r0 hard-wired to zero, and a debug write counter.
// Latency: reads are combinational (0 cycles); a write commits on the next rising clk edge, and is forwarded the same cycle when BYPASS=1.
// Backpressure: none; a write is accepted every cycle it is presented, and reads never stall.
module reg_file #(
  parameter bit BYPASS = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic [4:0]  rd_addr_a,
  input  logic [4:0]  rd_addr_b,
  output logic [31:0] rd_data_a,
  output logic [31:0] rd_data_b,
  output logic [7:0]  wr_count
);

  // r0 has no storage: it reads as a constant zero.
  logic [31:0] regs [1:31];
  logic [31:0] rd_tbl [32];
  logic [7:0]  count_q;
  logic        wr_commit;

  // Writes to r0 are dropped outright, so they neither store nor count.
  assign wr_commit = wr_en && (wr_addr != 5'd0);

  // Per-bit 32-to-1 selection as a five-level binary mux tree, one address bit per level.
  function automatic logic [31:0] sel32(input logic [31:0] tbl [32], input logic [4:0] addr);
    logic [31:0] lvl [32];
    lvl = tbl;
    for (int s = 0; s < 5; s++) begin
      for (int k = 0; k < (16 >> s); k++) begin
        lvl[k] = addr[s] ? lvl[2*k+1] : lvl[2*k];
      end
    end
    return lvl[0];
  endfunction

  // Storage update: asynchronous clear, then one commit per edge, last write wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 1; i < 32; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_commit) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Committed-write counter that saturates at 255 instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (wr_commit && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign wr_count = count_q;

  // Flatten storage into a 32-entry read table with entry 0 tied to zero.
  always_comb begin
    rd_tbl[0] = '0;
    for (int i = 1; i < 32; i++) begin
      rd_tbl[i] = regs[i];
    end
  end

  // Read port A: reset and r0 force zero; otherwise forward the in-flight write or select storage.
  always_comb begin
    rd_data_a = sel32(rd_tbl, rd_addr_a);
    if (BYPASS && wr_commit && (rd_addr_a == wr_addr)) begin
      rd_data_a = wr_data;
    end
    if (!rst_n || (rd_addr_a == 5'd0)) begin
      rd_data_a = '0;
    end
  end

  // Read port B: identical to port A, fully independent selection.
  always_comb begin
    rd_data_b = sel32(rd_tbl, rd_addr_b);
    if (BYPASS && wr_commit && (rd_addr_b == wr_addr)) begin
      rd_data_b = wr_data;
    end
    if (!rst_n || (rd_addr_b == 5'd0)) begin
      rd_data_b = '0;
    end
  end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr_a;
  logic [4:0]  rd_addr_b;
  logic [31:0] rd_data_a;
  logic [31:0] rd_data_b;
  logic [7:0]  wr_count;
  logic [31:0] nb_data_a;
  logic [31:0] nb_data_b;
  logic [7:0]  nb_count;

  int checks = 0;
  int errors = 0;

  // Forwarding instance
  reg_file #(.BYPASS(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b), .wr_count(wr_count)
  );

  // Non-forwarding instance driven by the same stimulus
  reg_file #(.BYPASS(1'b0)) dut_nb (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(nb_data_a), .rd_data_b(nb_data_b), .wr_count(nb_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b1;
    wr_addr = 5'd7;
    wr_data = 32'hCAFE_F00D;
    rd_addr_a = 5'd7;
    rd_addr_b = 5'd7;
    #1;
    // Bypass condition present while in reset: outputs must still be zero.
    check("rst_bypass_a", rd_data_a, 32'h0);
    check("rst_bypass_b", rd_data_b, 32'h0);
    check("rst_count", {24'h0, wr_count}, 32'h0);
    // An edge while in reset carries the write, which must be dropped.
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_en = 1'b0;
    // Full sweep of both ports after reset.
    for (int a = 0; a < 32; a++) begin
      rd_addr_a = a[4:0];
      rd_addr_b = 5'(31 - a);
      #1;
      check("sweep_a", rd_data_a, 32'h0);
      check("sweep_b", rd_data_b, 32'h0);
      check("sweep_nb_a", nb_data_a, 32'h0);
    end
    check("sweep_count", {24'h0, wr_count}, 32'h0);

    // Two writes, then read both back on separate ports.
    step();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD_BEEF;
    step();
    wr_addr = 5'd31; wr_data = 32'h1234_5678;
    step();
    wr_en = 1'b0; rd_addr_a = 5'd5; rd_addr_b = 5'd31;
    #1;
    check("r5_a", rd_data_a, 32'hDEAD_BEEF);
    check("r31_b", rd_data_b, 32'h1234_5678);
    check("r5_nb", nb_data_a, 32'hDEAD_BEEF);
    check("count2", {24'h0, wr_count}, 32'd2);
    check("count2_nb", {24'h0, nb_count}, 32'd2);

    // Write to r0 is discarded, including by the forwarding path.
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rd_addr_a = 5'd0;
    #1;
    check("r0_same_cycle", rd_data_a, 32'h0);
    step();
    wr_en = 1'b0;
    #1;
    check("r0_after", rd_data_a, 32'h0);
    check("r0_count", {24'h0, wr_count}, 32'd2);

    // Same-cycle forwarding versus old value.
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5_A5A5; rd_addr_a = 5'd7; rd_addr_b = 5'd7;
    #1;
    check("byp_a", rd_data_a, 32'hA5A5_A5A5);
    check("byp_b", rd_data_b, 32'hA5A5_A5A5);
    check("nobyp_a", nb_data_a, 32'h0);
    check("nobyp_b", nb_data_b, 32'h0);
    step();
    wr_en = 1'b0;
    #1;
    check("r7_after_byp", rd_data_a, 32'hA5A5_A5A5);
    check("r7_after_nobyp", nb_data_a, 32'hA5A5_A5A5);
    check("count3", {24'h0, wr_count}, 32'd3);

    // Both ports on the same register.
    rd_addr_a = 5'd5; rd_addr_b = 5'd5;
    #1;
    check("same_a", rd_data_a, 32'hDEAD_BEEF);
    check("same_b", rd_data_b, 32'hDEAD_BEEF);

    // Back-to-back writes to r9: last value wins.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h0000_0001;
    step();
    wr_data = 32'h0000_0002;
    step();
    wr_data = 32'h0000_0003;
    step();
    wr_en = 1'b0; rd_addr_a = 5'd9; rd_addr_b = 5'd7;
    #1;
    check("b2b_r9", rd_data_a, 32'h0000_0003);
    check("b2b_r9_nb", nb_data_a, 32'h0000_0003);
    check("b2b_r7_kept", rd_data_b, 32'hA5A5_A5A5);
    check("count6", {24'h0, wr_count}, 32'd6);

    // Unknown read addresses during a write must not disturb storage.
    wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h0BAD_F00D; rd_addr_a = 'x; rd_addr_b = 'x;
    step();
    wr_en = 1'b0; rd_addr_a = 5'd10; rd_addr_b = 5'd31;
    #1;
    check("xaddr_r10", rd_data_a, 32'h0BAD_F00D);
    check("xaddr_r31", rd_data_b, 32'h1234_5678);
    check("count7", {24'h0, wr_count}, 32'd7);

    // 300 writes to r1: counter saturates at 255, r1 holds the last value.
    wr_en = 1'b1; wr_addr = 5'd1;
    for (int i = 0; i < 300; i++) begin
      wr_data = 32'h1000_0000 + 32'(i);
      step();
      if (i == 99) begin
        check("count_mid", {24'h0, wr_count}, 32'd107);
      end
    end
    wr_en = 1'b0; rd_addr_a = 5'd1;
    #1;
    check("sat_count", {24'h0, wr_count}, 32'd255);
    check("sat_count_nb", {24'h0, nb_count}, 32'd255);
    check("sat_r1", rd_data_a, 32'h1000_012B);

    // Asynchronous reset asserted between edges.
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0055;
    step();
    wr_en = 1'b0; rd_addr_a = 5'd3; rd_addr_b = 5'd3;
    #1;
    check("r3_loaded", rd_data_a, 32'h0000_0055);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_r3_a", rd_data_a, 32'h0);
    check("rst_r3_nb", nb_data_b, 32'h0);
    check("rst_mid_count", {24'h0, wr_count}, 32'd0);
    #1;
    rst_n = 1'b1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h0000_0077;
    step();
    wr_en = 1'b0; rd_addr_b = 5'd9;
    #1;
    check("post_rst_r3", rd_data_a, 32'h0000_0077);
    check("post_rst_r9_cleared", rd_data_b, 32'h0);
    check("post_rst_count", {24'h0, wr_count}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
